// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage controller slice.
package mem_pkg;

    localparam int unsigned DATA_W_DEF      = 64;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;
    localparam int unsigned REG_ADDR_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/grant/response port used by the MEM-stage controller.
interface mem_stage_ctrl_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Access timeout counter: cleared on request start, counts while enabled,
// pulses expired in the TIMEOUT_CYC-th enabled cycle.
module mem_timeout_ctr
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory access FSM, pipeline stall, branch resolve
// and MEM/WB register. Optional misalignment check under MEM_MISALIGN_CHK_EN.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     aluresult_in,
    input  logic [DATA_W-1:0]     wdata_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  memread_in,
    input  logic                  memwrite_in,
    input  logic                  memtoreg_in,
    input  logic                  regwrite_in,
    input  logic                  branch_in,
    input  logic                  zero_in,
    mem_stage_ctrl_if.master      dmem,
    output logic                  stall,
    output logic                  pcsrc,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_aluresult,
    output logic [DATA_W-1:0]     wb_rdata,
    output logic                  err,
    output logic                  misalign
);

    mem_state_e state, state_next;

    logic mem_op;
    logic misalign_hit;
    logic start;
    logic bad_access;
    logic complete_load;
    logic timed_out;
    logic expired;

    assign mem_op     = memread_in | memwrite_in;
    assign start      = (state == IDLE) && mem_op && !misalign_hit;
    assign bad_access = (state == IDLE) && mem_op && misalign_hit;

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign_hit = (aluresult_in[2:0] != 3'b000);

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= bad_access;
        end
    end
`else
    assign misalign_hit = 1'b0;
    assign misalign     = 1'b0;
`endif

    mem_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable (state inside {REQ, WAIT}),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A completing store or load wins over timeout in the same cycle; a granted
    // load that has already expired is abandoned rather than moved to WAIT.
    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        complete_load = 1'b0;
        timed_out     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dmem.gnt && dmem.we) begin
                    state_next = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end else if (dmem.gnt) begin
                    stall      = 1'b1;
                    state_next = WAIT;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    complete_load = 1'b1;
                    state_next    = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pcsrc = branch_in && zero_in && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.wdata   <= '0;
            err          <= 1'b0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_rd        <= '0;
            wb_aluresult <= '0;
            wb_rdata     <= '0;
        end else begin
            dmem.req <= (state_next == REQ);
            if (start) begin
                dmem.we    <= memwrite_in;
                dmem.addr  <= aluresult_in;
                dmem.wdata <= wdata_in;
            end
            if (timed_out) begin
                err <= 1'b1;
            end
            if (stall) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
            end else begin
                wb_rd        <= rd_in;
                wb_memtoreg  <= memtoreg_in;
                wb_aluresult <= aluresult_in;
                if (timed_out || bad_access) begin
                    wb_valid    <= 1'b0;
                    wb_regwrite <= 1'b0;
                    wb_rdata    <= '0;
                end else begin
                    wb_valid    <= 1'b1;
                    wb_regwrite <= regwrite_in;
                    wb_rdata    <= complete_load ? dmem.rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected writebacks and memory requests
// are queued by the stimulus and popped by an independent monitor.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    localparam int unsigned DW = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  aluresult_in, wdata_in;
    logic [4:0]     rd_in;
    logic           memread_in, memwrite_in, memtoreg_in, regwrite_in, branch_in, zero_in;
    logic           stall, pcsrc, wb_valid, wb_regwrite, wb_memtoreg, err, misalign;
    logic [4:0]     wb_rd;
    logic [DW-1:0]  wb_aluresult, wb_rdata;

    mem_stage_ctrl_if #(.DATA_W(DW)) dmem ();

    mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .aluresult_in(aluresult_in), .wdata_in(wdata_in), .rd_in(rd_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
        .regwrite_in(regwrite_in), .branch_in(branch_in), .zero_in(zero_in),
        .dmem(dmem),
        .stall(stall), .pcsrc(pcsrc),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_rd(wb_rd), .wb_aluresult(wb_aluresult), .wb_rdata(wb_rdata),
        .err(err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rd;
        logic          rw;
        logic          mtr;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
    } wb_exp_t;

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int       checks = 0;
    int       failures = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin : monitor
        wb_exp_t  we_;
        req_exp_t re_;
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual rd=%0d required=no writeback", wb_rd);
            end else begin
                we_ = wb_q.pop_front();
                check("wb_rd", wb_rd, we_.rd);
                check("wb_regwrite", wb_regwrite, we_.rw);
                check("wb_memtoreg", wb_memtoreg, we_.mtr);
                check("wb_aluresult", wb_aluresult, we_.alu);
                check("wb_rdata", wb_rdata, we_.rdata);
            end
        end
        if (dmem.req === 1'b1 && dmem.gnt === 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL req_unexpected actual addr=%0h required=no request", dmem.addr);
            end else begin
                re_ = req_q.pop_front();
                check("dmem_we", dmem.we, re_.we);
                check("dmem_addr", dmem.addr, re_.addr);
                check("dmem_wdata", dmem.wdata, re_.wdata);
            end
        end
    end

    task automatic set_instr(input logic [4:0] rd, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                             input logic mr, input logic mw, input logic mtr, input logic rw,
                             input logic br, input logic z);
        rd_in = rd; aluresult_in = alu; wdata_in = wd;
        memread_in = mr; memwrite_in = mw; memtoreg_in = mtr;
        regwrite_in = rw; branch_in = br; zero_in = z;
    endtask

    task automatic set_nop();
        set_instr(5'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic rw, input logic mtr,
                           input logic [DW-1:0] alu, input logic [DW-1:0] rdata);
        wb_exp_t e;
        e.rd = rd; e.rw = rw; e.mtr = mtr; e.alu = alu; e.rdata = rdata;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
        req_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        req_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_cycle();
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_nop();
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        tick(); tick();

        // reset state
        @(negedge clk);
        check("rst_req", dmem.req, 0);
        check("rst_we", dmem.we, 0);
        check("rst_addr", dmem.addr, 0);
        check("rst_wdata", dmem.wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_rdata", wb_rdata, 0);
        check("rst_err", err, 0);
        check("rst_misalign", misalign, 0);
        check("rst_stall", stall, 0);
        tick();
        reset = 1'b0;
        nop_cycle();
        nop_cycle();

        // store, grant in first REQ cycle
        set_instr(5'd0, 64'h100, 64'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd0, 1'b0, 1'b0, 64'h100, '0);
        @(negedge clk);
        check("st_idle_stall", stall, 1);
        check("st_idle_req", dmem.req, 0);
        tick();
        dmem.gnt = 1'b1;
        push_req(1'b1, 64'h100, 64'hDEAD);
        @(negedge clk);
        check("st_req_stall", stall, 0);
        check("st_req_out", dmem.req, 1);
        tick();
        dmem.gnt = 1'b0;
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("st_wb_valid", wb_valid, 1);
        check("st_req_dropped", dmem.req, 0);
        tick();

        // load: stray rvalid in REQ, gnt in 2nd REQ cycle, rvalid 3 cycles later
        set_instr(5'd5, 64'h200, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_wb(5'd5, 1'b1, 1'b1, 64'h200, 64'h1234);
        push_req(1'b0, 64'h200, '0);
        @(negedge clk);
        check("ld_idle_stall", stall, 1);
        tick();
        dmem.rvalid = 1'b1; dmem.rdata = 64'hBAD;
        @(negedge clk);
        check("ld_req1_stall", stall, 1);
        tick();
        dmem.rvalid = 1'b0; dmem.gnt = 1'b1;
        @(negedge clk);
        check("ld_req2_stall", stall, 1);
        check("ld_req2_req", dmem.req, 1);
        tick();
        dmem.gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ld_wait_stall", stall, 1);
            check("ld_wait_req", dmem.req, 0);
            tick();
        end
        dmem.rvalid = 1'b1; dmem.rdata = 64'h1234;
        @(negedge clk);
        check("ld_done_stall", stall, 0);
        tick();
        dmem.rvalid = 1'b0; dmem.rdata = '0;
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("ld_wb_valid", wb_valid, 1);
        tick();

        // branch resolution
        set_instr(5'd0, 64'h40, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_wb(5'd0, 1'b0, 1'b0, 64'h40, '0);
        @(negedge clk);
        check("br_taken_pcsrc", pcsrc, 1);
        check("br_taken_stall", stall, 0);
        tick();
        set_instr(5'd0, 64'h40, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_wb(5'd0, 1'b0, 1'b0, 64'h40, '0);
        @(negedge clk);
        check("br_nottaken_pcsrc", pcsrc, 0);
        tick();
        set_instr(5'd0, 64'h108, 64'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        push_wb(5'd0, 1'b0, 1'b0, 64'h108, '0);
        @(negedge clk);
        check("br_stalled_pcsrc", pcsrc, 0);
        tick();
        dmem.gnt = 1'b1;
        push_req(1'b1, 64'h108, 64'h5);
        @(negedge clk);
        check("br_complete_pcsrc", pcsrc, 1);
        tick();
        dmem.gnt = 1'b0;
        nop_cycle();

        // timeout: load never granted
        set_instr(5'd7, 64'h300, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        dmem.rdata = 64'hBAD;
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 14) check("to_stall_before", stall, 1);
            if (i == 15) begin
                check("to_stall_expire", stall, 0);
                check("to_err_before", err, 0);
            end
            tick();
        end
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("to_err_set", err, 1);
        check("to_wb_regwrite", wb_regwrite, 0);
        check("to_wb_rdata", wb_rdata, 0);
        check("to_req_dropped", dmem.req, 0);
        tick();
        dmem.rdata = '0;
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("to_err_sticky", err, 1);
        tick();

        // reset during WAIT, then a late rvalid
        set_instr(5'd9, 64'h400, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_req(1'b0, 64'h400, '0);
        tick();
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        @(negedge clk);
        check("rw_wait_stall", stall, 1);
        reset = 1'b1;
        set_nop();
        tick();
        @(negedge clk);
        check("rw_req", dmem.req, 0);
        check("rw_addr", dmem.addr, 0);
        check("rw_wb_valid", wb_valid, 0);
        check("rw_wb_aluresult", wb_aluresult, 0);
        check("rw_err_cleared", err, 0);
        check("rw_stall", stall, 0);
        tick();
        reset = 1'b0;
        dmem.rvalid = 1'b1; dmem.rdata = 64'hBEEF;
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rw_late_stall", stall, 0);
        tick();
        dmem.rvalid = 1'b0; dmem.rdata = '0;
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rw_late_rdata", wb_rdata, 0);
        check("rw_late_req", dmem.req, 0);
        tick();

`ifdef MEM_MISALIGN_CHK_EN
        // misaligned load is dropped as a bubble
        set_instr(5'd3, 64'h103, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ma_stall", stall, 0);
        tick();
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("ma_pulse", misalign, 1);
        check("ma_wb_regwrite", wb_regwrite, 0);
        check("ma_req", dmem.req, 0);
        tick();
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("ma_pulse_end", misalign, 0);
        tick();
`else
        // unaligned address passes through untouched
        set_instr(5'd3, 64'h103, 64'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd3, 1'b0, 1'b0, 64'h103, '0);
        @(negedge clk);
        check("ua_stall", stall, 1);
        tick();
        dmem.gnt = 1'b1;
        push_req(1'b1, 64'h103, 64'h99);
        @(negedge clk);
        check("ua_misalign", misalign, 0);
        tick();
        dmem.gnt = 1'b0;
        set_nop();
        push_wb(5'd0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("ua_misalign_after", misalign, 0);
        tick();
`endif

        nop_cycle();
        @(negedge clk);
        #1;
        check("wb_q_drained", wb_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller that consumes the EX/MEM pipeline register outputs.
- Drives a request/grant/response data-memory port for loads and stores.
- Stalls the pipeline while an access is outstanding, resolves the branch (pcsrc), and registers the MEM/WB fields for the writeback stage.
- Sits between the EX/MEM register and the WB mux.

Parameters:
- DATA_W, 64, width of address, ALU result and data buses
- TIMEOUT_CYC, 16, max cycles in REQ+WAIT before an access is abandoned

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- aluresult_in  in  DATA_W  EX/MEM ALU result (memory address for loads/stores)
- wdata_in  in  DATA_W  EX/MEM forwarded store data
- rd_in  in  5  destination register
- memread_in, memwrite_in, memtoreg_in, regwrite_in, branch_in, zero_in  in  1 each  EX/MEM control and zero flag
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  memory address
- dmem_wdata  out  DATA_W  store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_W  load data
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pcsrc  out  1  take branch
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control
- wb_rd  out  5  MEM/WB destination register
- wb_aluresult, wb_rdata  out  DATA_W  MEM/WB ALU result and load data
- err  out  1  sticky timeout flag
- misalign  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high, at posedge. State goes to IDLE, timeout counter to 0. All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, err, misalign. Reset mid-access abandons it; no further dmem_req is issued, and any late gnt/rvalid is ignored in IDLE.
- mem_op = memread_in | memwrite_in. If both are set, the store wins and memread_in is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE & mem_op: latch address/data/we into dmem_* registers; go to REQ.
  - REQ: dmem_req=1, held until dmem_gnt.
    - Store & gnt: complete, go to IDLE.
    - Load & gnt: go to WAIT.
    - dmem_rvalid in REQ is ignored; memory returns load data no earlier than the cycle after gnt.
  - WAIT: dmem_req=0. On dmem_rvalid: complete, go to IDLE.
- stall (combinational) = (IDLE & mem_op) | (REQ & !(store & gnt)) | (WAIT & !rvalid).
  - A load costs a minimum of 3 cycles (IDLE, REQ+gnt, WAIT+rvalid); a store costs a minimum of 2.
  - stall falls in the completing cycle, so the next instruction enters EX/MEM on that edge.
- MEM/WB update each posedge:
  - !stall: wb_valid=1; wb_rd, wb_regwrite, wb_memtoreg, wb_aluresult take the inputs. wb_rdata = dmem_rdata on a completing load, else 0.
  - stall: bubble; wb_valid=0, wb_regwrite=0; other wb_* hold.
- pcsrc (combinational) = branch_in & zero_in & !stall.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - At TIMEOUT_CYC: err set (sticky until reset); go to IDLE; the instruction completes as a bubble (wb_regwrite=0, wb_rdata=0).
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Address is a byte address passed through unmodified; only full DATA_W accesses are supported.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- Defined: in IDLE, mem_op with aluresult_in[2:0]!=0 issues no request and stall stays low. The instruction completes as a bubble (wb_regwrite=0), and misalign is registered high for exactly one cycle.
- Undefined: no check is made, the unaligned address goes to memory, and misalign is tied 0.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT, 2-bit);
  - DATA_W_DEF=64 and TIMEOUT_CYC_DEF=16;
  - the REG_ADDR_W=5 constant.
- One sub-module, mem_timeout_ctr: clear, enable and TIMEOUT_CYC parameter in; expired pulse out.

Test Plan:
- Store, gnt in the first REQ cycle: memwrite_in=1, aluresult_in=64'h100, wdata_in=64'hDEAD -> dmem_req/we=1, addr=64'h100, wdata=64'hDEAD; stall high for 1 cycle; wb_valid=1 after 2 cycles; dmem_req=0 afterwards.
- Load with 3-cycle rvalid latency: memread_in=1, addr=64'h200, rd=5; gnt after 2 cycles, rvalid with rdata=64'h1234 3 cycles later -> stall continuous until rvalid; wb_rdata=64'h1234, wb_rd=5, wb_valid=1 for one cycle.
- Branch: branch_in=1, zero_in=1, no mem op -> pcsrc=1 the same cycle, stall=0; with zero_in=0 -> pcsrc=0.
- Timeout: load with gnt never asserted -> after 16 cycles err=1 and stays 1, stall drops, wb_regwrite=0, wb_rdata=0.
- Reset mid-WAIT: reset during WAIT with a late rvalid afterwards -> all outputs 0, state IDLE, and the rvalid produces no wb_valid.
- MEM_MISALIGN_CHK_EN defined: load at 64'h103 -> no dmem_req, misalign high for 1 cycle, wb_regwrite=0.
